// File: rtl/mixer_layer_scheduler.sv
// Avalon-MM master for the VIP Mixer control slave: boot programming of all
// layers, then round-robin atomic X/Y/CTRL updates from two requesters.
module mixer_layer_scheduler #(
    parameter int unsigned NUM_LAYERS   = 2,
    parameter int unsigned LAYER_BASE   = 8,
    parameter int unsigned LAYER_STRIDE = 5,
    parameter logic [15:0] BOOT_X       = 16'd0,
    parameter logic [15:0] BOOT_Y       = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a_valid,
    input  logic [2:0]  req_a_layer,
    input  logic [15:0] req_a_x,
    input  logic [15:0] req_a_y,
    input  logic        req_a_en,
    output logic        req_a_ready,
    input  logic        req_b_valid,
    input  logic [2:0]  req_b_layer,
    input  logic [15:0] req_b_x,
    input  logic [15:0] req_b_y,
    input  logic        req_b_en,
    output logic        req_b_ready,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    output logic [10:0] avm_burstcount,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    output logic        boot_done,
    output logic        busy,
    output logic        err_layer
);

    typedef enum logic [3:0] {
        S_BOOT_STOP,
        S_BOOT_LX,
        S_BOOT_LY,
        S_BOOT_LC,
        S_BOOT_GO,
        S_IDLE,
        S_UPD_X,
        S_UPD_Y,
        S_UPD_CTRL
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  layer_q, layer_d;
    logic [15:0] lat_x_q, lat_x_d;
    logic [15:0] lat_y_q, lat_y_d;
    logic        lat_en_q, lat_en_d;
    logic        last_a_q, last_a_d;
    logic        req_a_ready_q, req_a_ready_d;
    logic        req_b_ready_q, req_b_ready_d;
    logic        err_layer_q, err_layer_d;
    logic [31:0] avm_address_q, avm_address_d;
    logic [31:0] avm_writedata_q, avm_writedata_d;
    logic        avm_write_q, avm_write_d;
    logic [3:0]  avm_byteenable_q, avm_byteenable_d;
    logic [10:0] avm_burstcount_q, avm_burstcount_d;
    logic        boot_done_q, boot_done_d;
    logic        busy_q, busy_d;

    logic        issue;
    logic        a_ok, b_ok, pick_b;
    logic [2:0]  req_layer;
    logic [15:0] req_x, req_y;
    logic        req_en;

    function automatic logic [31:0] layer_addr(input logic [2:0] layer, input logic [1:0] off);
        return 32'(LAYER_BASE + 32'(layer) * LAYER_STRIDE + 32'(off));
    endfunction

    // Next-state and next-output computation; the output registers always hold
    // the write belonging to the current state, so a completed write loads the
    // following one on the same edge and unstalled writes run back to back.
    always_comb begin
        state_d       = state_q;
        layer_d       = layer_q;
        lat_x_d       = lat_x_q;
        lat_y_d       = lat_y_q;
        lat_en_d      = lat_en_q;
        last_a_d      = last_a_q;
        req_a_ready_d = 1'b0;
        req_b_ready_d = 1'b0;
        err_layer_d   = 1'b0;
        issue         = 1'b0;

        // A requester whose ready is currently pulsing is not re-granted on
        // the same still-high valid.
        a_ok      = req_a_valid && !req_a_ready_q;
        b_ok      = req_b_valid && !req_b_ready_q;
        pick_b    = b_ok && (!a_ok || last_a_q);
        req_layer = pick_b ? req_b_layer : req_a_layer;
        req_x     = pick_b ? req_b_x     : req_a_x;
        req_y     = pick_b ? req_b_y     : req_a_y;
        req_en    = pick_b ? req_b_en    : req_a_en;

        case (state_q)
            S_IDLE: begin
                if (a_ok || b_ok) begin
                    last_a_d      = !pick_b;
                    req_a_ready_d = !pick_b;
                    req_b_ready_d = pick_b;
                    if ({1'b0, req_layer} >= 4'(NUM_LAYERS)) begin
                        err_layer_d = 1'b1;
                    end else begin
                        state_d  = S_UPD_X;
                        layer_d  = req_layer;
                        lat_x_d  = req_x;
                        lat_y_d  = req_y;
                        lat_en_d = req_en;
                        issue    = 1'b1;
                    end
                end
            end
            default: begin
                if (!avm_write_q) begin
                    // only reachable in BOOT_STOP right after reset
                    issue = 1'b1;
                end else if (!avm_waitrequest) begin
                    issue = 1'b1;
                    case (state_q)
                        S_BOOT_STOP: begin
                            state_d = S_BOOT_LX;
                            layer_d = '0;
                        end
                        S_BOOT_LX: state_d = S_BOOT_LY;
                        S_BOOT_LY: state_d = S_BOOT_LC;
                        S_BOOT_LC: begin
                            if (32'(layer_q) == NUM_LAYERS - 1) begin
                                state_d = S_BOOT_GO;
                            end else begin
                                state_d = S_BOOT_LX;
                                layer_d = layer_q + 3'd1;
                            end
                        end
                        S_UPD_X:   state_d = S_UPD_Y;
                        S_UPD_Y:   state_d = S_UPD_CTRL;
                        default: begin
                            state_d = S_IDLE;
                            issue   = 1'b0;
                        end
                    endcase
                end
            end
        endcase

        avm_write_d     = issue || (avm_write_q && state_d != S_IDLE);
        avm_address_d   = avm_address_q;
        avm_writedata_d = avm_writedata_q;
        if (issue) begin
            case (state_d)
                S_BOOT_STOP: begin
                    avm_address_d   = '0;
                    avm_writedata_d = '0;
                end
                S_BOOT_GO: begin
                    avm_address_d   = '0;
                    avm_writedata_d = 32'd1;
                end
                S_BOOT_LX: begin
                    avm_address_d   = layer_addr(layer_d, 2'd0);
                    avm_writedata_d = {16'b0, BOOT_X};
                end
                S_BOOT_LY: begin
                    avm_address_d   = layer_addr(layer_d, 2'd1);
                    avm_writedata_d = {16'b0, BOOT_Y};
                end
                S_BOOT_LC: begin
                    avm_address_d   = layer_addr(layer_d, 2'd2);
                    avm_writedata_d = 32'd1;
                end
                S_UPD_X: begin
                    avm_address_d   = layer_addr(layer_d, 2'd0);
                    avm_writedata_d = {16'b0, lat_x_d};
                end
                S_UPD_Y: begin
                    avm_address_d   = layer_addr(layer_d, 2'd1);
                    avm_writedata_d = {16'b0, lat_y_d};
                end
                S_UPD_CTRL: begin
                    avm_address_d   = layer_addr(layer_d, 2'd2);
                    avm_writedata_d = {31'b0, lat_en_d};
                end
                default: begin
                    avm_address_d   = avm_address_q;
                    avm_writedata_d = avm_writedata_q;
                end
            endcase
        end
        avm_byteenable_d = avm_write_d ? 4'hF : '0;
        avm_burstcount_d = avm_write_d ? 11'd1 : '0;
        boot_done_d      = boot_done_q || (state_d == S_IDLE);
        busy_d           = (state_d != S_IDLE);
    end

    // State and registered outputs; synchronous active-high reset restarts boot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_BOOT_STOP;
            layer_q          <= '0;
            lat_x_q          <= '0;
            lat_y_q          <= '0;
            lat_en_q         <= 1'b0;
            last_a_q         <= 1'b0;
            req_a_ready_q    <= 1'b0;
            req_b_ready_q    <= 1'b0;
            err_layer_q      <= 1'b0;
            avm_address_q    <= '0;
            avm_writedata_q  <= '0;
            avm_write_q      <= 1'b0;
            avm_byteenable_q <= '0;
            avm_burstcount_q <= '0;
            boot_done_q      <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            layer_q          <= layer_d;
            lat_x_q          <= lat_x_d;
            lat_y_q          <= lat_y_d;
            lat_en_q         <= lat_en_d;
            last_a_q         <= last_a_d;
            req_a_ready_q    <= req_a_ready_d;
            req_b_ready_q    <= req_b_ready_d;
            err_layer_q      <= err_layer_d;
            avm_address_q    <= avm_address_d;
            avm_writedata_q  <= avm_writedata_d;
            avm_write_q      <= avm_write_d;
            avm_byteenable_q <= avm_byteenable_d;
            avm_burstcount_q <= avm_burstcount_d;
            boot_done_q      <= boot_done_d;
            busy_q           <= busy_d;
        end
    end

    assign req_a_ready    = req_a_ready_q;
    assign req_b_ready    = req_b_ready_q;
    assign err_layer      = err_layer_q;
    assign avm_address    = avm_address_q;
    assign avm_writedata  = avm_writedata_q;
    assign avm_write      = avm_write_q;
    assign avm_byteenable = avm_byteenable_q;
    assign avm_burstcount = avm_burstcount_q;
    assign avm_read       = 1'b0;
    assign boot_done      = boot_done_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_mixer_layer_scheduler.sv
// Bench for mixer_layer_scheduler: queue-based reference model checked every
// cycle, directed boot/arbitration/error/reset scenarios, then random traffic.
module tb_mixer_layer_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_a_valid = 1'b0;
    logic [2:0]  req_a_layer = '0;
    logic [15:0] req_a_x = '0, req_a_y = '0;
    logic        req_a_en = 1'b0;
    logic        req_a_ready;
    logic        req_b_valid = 1'b0;
    logic [2:0]  req_b_layer = '0;
    logic [15:0] req_b_x = '0, req_b_y = '0;
    logic        req_b_en = 1'b0;
    logic        req_b_ready;
    logic [31:0] avm_address, avm_writedata;
    logic        avm_write, avm_read;
    logic [3:0]  avm_byteenable;
    logic [10:0] avm_burstcount;
    logic        avm_waitrequest = 1'b0;
    logic        boot_done, busy, err_layer;

    always #5 clk = ~clk;

    mixer_layer_scheduler #(
        .NUM_LAYERS(2), .LAYER_BASE(8), .LAYER_STRIDE(5), .BOOT_X(16'd0), .BOOT_Y(16'd0)
    ) dut (
        .clk(clk), .reset(reset),
        .req_a_valid(req_a_valid), .req_a_layer(req_a_layer), .req_a_x(req_a_x),
        .req_a_y(req_a_y), .req_a_en(req_a_en), .req_a_ready(req_a_ready),
        .req_b_valid(req_b_valid), .req_b_layer(req_b_layer), .req_b_x(req_b_x),
        .req_b_y(req_b_y), .req_b_en(req_b_en), .req_b_ready(req_b_ready),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
        .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
        .boot_done(boot_done), .busy(busy), .err_layer(err_layer)
    );

    int unsigned total = 0;
    int unsigned bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: pending write list ----------------
    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t  pend[$];
    wr_t  m_cur;
    logic m_write = 1'b0, m_ra = 1'b0, m_rb = 1'b0, m_err = 1'b0, m_boot = 1'b0;
    logic m_last_a = 1'b0;
    bit   m_live = 1'b0;

    function automatic void push_layer(input int unsigned layer, input logic [15:0] x,
                                       input logic [15:0] y, input logic en);
        int unsigned base;
        base = 8 + layer * 5;
        pend.push_back('{base, {16'b0, x}});
        pend.push_back('{base + 1, {16'b0, y}});
        pend.push_back('{base + 2, {31'b0, en}});
    endfunction

    always @(posedge clk) begin
        bit idle, take_b;
        logic [2:0] l;
        m_live = 1'b1;
        if (reset) begin
            pend.delete();
            pend.push_back('{32'd0, 32'd0});
            for (int i = 0; i < 2; i++) push_layer(i, 16'd0, 16'd0, 1'b1);
            pend.push_back('{32'd0, 32'd1});
            m_write = 0; m_ra = 0; m_rb = 0; m_err = 0; m_boot = 0; m_last_a = 0;
        end else begin
            idle = m_boot && !m_write;
            m_ra = 0; m_rb = 0; m_err = 0;
            if (m_write && !avm_waitrequest) void'(pend.pop_front());
            if (idle && (req_a_valid || req_b_valid)) begin
                take_b   = req_b_valid && (!req_a_valid || m_last_a);
                m_last_a = !take_b;
                m_ra     = !take_b;
                m_rb     = take_b;
                l        = take_b ? req_b_layer : req_a_layer;
                if (l >= 3'd2) m_err = 1;
                else if (take_b) push_layer(l, req_b_x, req_b_y, req_b_en);
                else push_layer(l, req_a_x, req_a_y, req_a_en);
            end
            m_write = (pend.size() != 0);
            if (m_write) m_cur = pend[0];
            if (pend.size() == 0) m_boot = 1;
        end
    end

    // ---------------- per-cycle compare and observation ----------------
    wr_t obs[$];
    int unsigned cnt_ra = 0, cnt_rb = 0, cnt_err = 0, cnt_a9 = 0;

    always @(negedge clk) begin
        if (m_live) begin
            chk("avm_write", avm_write, m_write);
            if (m_write) begin
                chk("avm_address", avm_address, m_cur.a);
                chk("avm_writedata", avm_writedata, m_cur.d);
            end
            chk("avm_byteenable", avm_byteenable, m_write ? 4'hF : 4'h0);
            chk("avm_burstcount", avm_burstcount, m_write ? 11'd1 : 11'd0);
            chk("avm_read", avm_read, 1'b0);
            chk("req_a_ready", req_a_ready, m_ra);
            chk("req_b_ready", req_b_ready, m_rb);
            chk("err_layer", err_layer, m_err);
            chk("boot_done", boot_done, m_boot);
            chk("busy", busy, m_write);
        end
        if (avm_write === 1'b1 && !avm_waitrequest) obs.push_back('{avm_address, avm_writedata});
        if (req_a_ready === 1'b1) cnt_ra++;
        if (req_b_ready === 1'b1) cnt_rb++;
        if (err_layer === 1'b1) cnt_err++;
        if (avm_write === 1'b1 && avm_address == 32'd9) cnt_a9++;
    end

    // ---------------- stimulus ----------------
    int unsigned wr_mode = 0;   // 0: never stall, 1: stall addr 9 five cycles, 2: random
    int unsigned stall_cnt = 0;
    bit rnd = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
        if (req_a_valid && req_a_ready) req_a_valid = 1'b0;
        else if (rnd && !req_a_valid && $urandom_range(0, 3) == 0) begin
            req_a_layer = 3'($urandom_range(0, 3));
            req_a_x = 16'($urandom); req_a_y = 16'($urandom); req_a_en = 1'($urandom);
            req_a_valid = 1'b1;
        end
        if (req_b_valid && req_b_ready) req_b_valid = 1'b0;
        else if (rnd && !req_b_valid && $urandom_range(0, 3) == 0) begin
            req_b_layer = 3'($urandom_range(0, 3));
            req_b_x = 16'($urandom); req_b_y = 16'($urandom); req_b_en = 1'($urandom);
            req_b_valid = 1'b1;
        end
        case (wr_mode)
            1: begin
                if (avm_write && avm_address == 32'd9 && stall_cnt < 5) begin
                    avm_waitrequest = 1'b1;
                    stall_cnt++;
                end else avm_waitrequest = 1'b0;
            end
            2: avm_waitrequest = ($urandom_range(0, 3) == 0);
            default: avm_waitrequest = 1'b0;
        endcase
    endtask

    task automatic wait_boot(input string tag, input int unsigned lim, output int unsigned cyc);
        cyc = 0;
        while (!boot_done && cyc < lim) begin
            step();
            cyc++;
        end
        chk({tag, "_boot_reached"}, boot_done, 1'b1);
    endtask

    task automatic check_seq(input string tag, input int unsigned start, input int unsigned n,
                             input logic [31:0] ea[8], input logic [31:0] ed[8]);
        chk({tag, "_nwrites"}, 32'(obs.size() - start), n);
        for (int i = 0; i < n; i++) begin
            if (start + i < obs.size()) begin
                chk({tag, "_addr"}, obs[start + i].a, ea[i]);
                chk({tag, "_data"}, obs[start + i].d, ed[i]);
            end
        end
    endtask

    logic [31:0] boot_a[8] = '{0, 8, 9, 10, 13, 14, 15, 0};
    logic [31:0] boot_d[8] = '{0, 0, 0, 1, 0, 0, 1, 1};
    logic [31:0] t3_a[8]   = '{13, 14, 15, 8, 9, 10, 0, 0};
    logic [31:0] t3_d[8]   = '{100, 40, 1, 7, 3, 0, 0, 0};

    initial begin
        int unsigned s, cyc, snap_a, snap_b, snap_e, snap_9, k, boot_k, rdy_k;
        bit seen;

        // 1: plain boot
        repeat (3) step();
        chk("reset_write", avm_write, 1'b0);
        chk("reset_boot_done", boot_done, 1'b0);
        reset = 1'b0;
        s = obs.size();
        wait_boot("t1", 40, cyc);
        chk("t1_boot_cycles", cyc, 9);
        check_seq("t1", s, 8, boot_a, boot_d);

        // 2: stall on address 9
        wr_mode = 1; stall_cnt = 0;
        reset = 1'b1; step(); reset = 1'b0;
        s = obs.size(); snap_9 = cnt_a9;
        wait_boot("t2", 60, cyc);
        chk("t2_boot_cycles", cyc, 14);
        chk("t2_addr9_hold", cnt_a9 - snap_9, 6);
        check_seq("t2", s, 8, boot_a, boot_d);
        wr_mode = 0;

        // 3: simultaneous requests, first contention goes to A
        s = obs.size(); snap_a = cnt_ra; snap_b = cnt_rb;
        req_a_layer = 3'd1; req_a_x = 16'd100; req_a_y = 16'd40; req_a_en = 1'b1; req_a_valid = 1'b1;
        req_b_layer = 3'd0; req_b_x = 16'd7;   req_b_y = 16'd3;  req_b_en = 1'b0; req_b_valid = 1'b1;
        k = 0;
        do begin step(); k++; end while ((req_a_valid || req_b_valid || busy) && k < 40);
        chk("t3_done", k < 40, 1'b1);
        check_seq("t3", s, 6, t3_a, t3_d);
        chk("t3_ready_a_pulses", cnt_ra - snap_a, 1);
        chk("t3_ready_b_pulses", cnt_rb - snap_b, 1);

        // 4: out-of-range layer
        s = obs.size(); snap_e = cnt_err;
        req_a_layer = 3'd5; req_a_x = 16'h1111; req_a_y = 16'h2222; req_a_en = 1'b1; req_a_valid = 1'b1;
        seen = 0; k = 0;
        while (!seen && k < 10) begin
            step(); k++;
            if (req_a_ready) begin
                seen = 1;
                chk("t4_err_with_ready", err_layer, 1'b1);
            end
        end
        chk("t4_ready_seen", seen, 1'b1);
        repeat (3) step();
        chk("t4_no_writes", 32'(obs.size() - s), 0);
        chk("t4_err_pulses", cnt_err - snap_e, 1);
        chk("t4_idle", busy, 1'b0);

        // 5: reset during the Y write of an update
        req_a_layer = 3'd0; req_a_x = 16'h1234; req_a_y = 16'h0055; req_a_en = 1'b1; req_a_valid = 1'b1;
        k = 0;
        do begin step(); k++; end while (!(avm_write && avm_address == 32'd9) && k < 20);
        chk("t5_upd_y_reached", avm_address, 32'd9);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t5_write_dropped", avm_write, 1'b0);
        s = obs.size();
        wait_boot("t5", 40, cyc);
        chk("t5_boot_cycles", cyc, 9);
        check_seq("t5", s, 8, boot_a, boot_d);

        // 6: request held during boot
        reset = 1'b1; step(); reset = 1'b0;
        req_b_layer = 3'd1; req_b_x = 16'd9; req_b_y = 16'd9; req_b_en = 1'b1; req_b_valid = 1'b1;
        k = 0; boot_k = 0; rdy_k = 0; seen = 0;
        while (!seen && k < 40) begin
            step(); k++;
            if (boot_done && boot_k == 0) boot_k = k;
            if (req_b_ready) begin seen = 1; rdy_k = k; end
        end
        chk("t6_ready_seen", seen, 1'b1);
        chk("t6_ready_after_boot", rdy_k - boot_k, 1);
        k = 0;
        while (busy && k < 20) begin step(); k++; end

        // random traffic with random stalls
        wr_mode = 2; rnd = 1'b1;
        repeat (800) step();
        wr_mode = 0; rnd = 1'b0;
        k = 0;
        while ((req_a_valid || req_b_valid || busy) && k < 80) begin step(); k++; end
        chk("drain", k < 80, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
